// File: rtl/vga_plot_pkg.sv
// Shared widths, screen bounds and arbiter state encoding for the VGA pixel-port arbiter.
package vga_plot_pkg;

   localparam int unsigned X_W_DEF  = 8;
   localparam int unsigned Y_W_DEF  = 7;
   localparam int unsigned C_W_DEF  = 3;
   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_BG  = 2'd1,
      GNT_OBJ = 2'd2,
      TURN    = 2'd3
   } arbState_t;

endpackage

// File: rtl/vga_plot_clip.sv
// Combinational on-screen test for a pixel coordinate.
module vga_plot_clip
   import vga_plot_pkg::*;
#(
   parameter int unsigned X_W = X_W_DEF,
   parameter int unsigned Y_W = Y_W_DEF
) (
   input  logic [X_W-1:0] pixX,
   input  logic [Y_W-1:0] pixY,
   output logic           inBounds_c
);

   assign inBounds_c = (32'(pixX) < SCREEN_W) && (32'(pixY) < SCREEN_H);

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter giving the background or object drawer burst ownership of the vga_adapter port.
// Define VGA_PLOT_CLIP_EN to suppress plots of accepted pixels that fall off the 160x120 screen.
module vga_plot_arbiter
   import vga_plot_pkg::*;
#(
   parameter int unsigned X_W = X_W_DEF,
   parameter int unsigned Y_W = Y_W_DEF,
   parameter int unsigned C_W = C_W_DEF
) (
   input  logic           Clock,
   input  logic           Reset,

   input  logic           bg_req,
   input  logic           bg_valid,
   input  logic           bg_last,
   input  logic [X_W-1:0] bg_x,
   input  logic [Y_W-1:0] bg_y,
   input  logic [C_W-1:0] bg_colour,
   output logic           bg_gnt,
   output logic           bg_done,

   input  logic           obj_req,
   input  logic           obj_valid,
   input  logic           obj_last,
   input  logic [X_W-1:0] obj_x,
   input  logic [Y_W-1:0] obj_y,
   input  logic [C_W-1:0] obj_colour,
   output logic           obj_gnt,
   output logic           obj_done,

   output logic           plot,
   output logic [X_W-1:0] vga_x,
   output logic [Y_W-1:0] vga_y,
   output logic [C_W-1:0] vga_colour,
   output logic           busy
);

   arbState_t      stateQ, stateD;
   logic           lastObjQ, lastObjD;
   logic           pixAccept;
   logic [X_W-1:0] pixX;
   logic [Y_W-1:0] pixY;
   logic [C_W-1:0] pixColour;
   logic           bgDoneD, objDoneD;
   logic           inBounds;

`ifdef VGA_PLOT_CLIP_EN
   vga_plot_clip #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_clip (
      .pixX       (pixX),
      .pixY       (pixY),
      .inBounds_c (inBounds)
   );
`else
   assign inBounds = 1'b1;
`endif

   // Next-state, pixel mux and burst-completion decode; a dropped req wins over a same-cycle valid.
   always_comb begin
      stateD    = stateQ;
      lastObjD  = lastObjQ;
      pixAccept = 1'b0;
      pixX      = bg_x;
      pixY      = bg_y;
      pixColour = bg_colour;
      bgDoneD   = 1'b0;
      objDoneD  = 1'b0;

      case (stateQ)
         IDLE: begin
            if (bg_req && (!obj_req || lastObjQ)) begin
               stateD   = GNT_BG;
               lastObjD = 1'b0;
            end else if (obj_req) begin
               stateD   = GNT_OBJ;
               lastObjD = 1'b1;
            end
         end
         GNT_BG: begin
            pixAccept = bg_req && bg_valid;
            if (!bg_req || (bg_valid && bg_last)) begin
               stateD  = TURN;
               bgDoneD = 1'b1;
            end
         end
         GNT_OBJ: begin
            pixAccept = obj_req && obj_valid;
            pixX      = obj_x;
            pixY      = obj_y;
            pixColour = obj_colour;
            if (!obj_req || (obj_valid && obj_last)) begin
               stateD   = TURN;
               objDoneD = 1'b1;
            end
         end
         TURN:    stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // All outputs registered; grants and busy follow the state being entered.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stateQ     <= IDLE;
         lastObjQ   <= 1'b1;
         bg_gnt     <= 1'b0;
         obj_gnt    <= 1'b0;
         busy       <= 1'b0;
         bg_done    <= 1'b0;
         obj_done   <= 1'b0;
         plot       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
      end else begin
         stateQ   <= stateD;
         lastObjQ <= lastObjD;
         bg_gnt   <= (stateD == GNT_BG);
         obj_gnt  <= (stateD == GNT_OBJ);
         busy     <= (stateD != IDLE);
         bg_done  <= bgDoneD;
         obj_done <= objDoneD;
         plot     <= pixAccept && inBounds;
         if (pixAccept && inBounds) begin
            vga_x      <= pixX;
            vga_y      <= pixY;
            vga_colour <= pixColour;
         end
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed scoreboard bench for vga_plot_arbiter; clip expectations follow VGA_PLOT_CLIP_EN.
module tb_vga_plot_arbiter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       Clock, Reset;
   logic       bg_req, bg_valid, bg_last, bg_gnt, bg_done;
   logic [7:0] bg_x;
   logic [6:0] bg_y;
   logic [2:0] bg_colour;
   logic       obj_req, obj_valid, obj_last, obj_gnt, obj_done;
   logic [7:0] obj_x;
   logic [6:0] obj_y;
   logic [2:0] obj_colour;
   logic       plot, busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int   nCmp = 0;
   int   nErr = 0;
   bit   expPlot = 1'b0;
   pix_t sb[$];

   vga_plot_arbiter dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .bg_req     (bg_req),
      .bg_valid   (bg_valid),
      .bg_last    (bg_last),
      .bg_x       (bg_x),
      .bg_y       (bg_y),
      .bg_colour  (bg_colour),
      .bg_gnt     (bg_gnt),
      .bg_done    (bg_done),
      .obj_req    (obj_req),
      .obj_valid  (obj_valid),
      .obj_last   (obj_last),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .obj_colour (obj_colour),
      .obj_gnt    (obj_gnt),
      .obj_done   (obj_done),
      .plot       (plot),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .busy       (busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkCtl(input string tag, input logic bg, input logic obj, input logic bz,
                         input logic bd, input logic od);
      chk({tag, ".bg_gnt"},   32'(bg_gnt),   32'(bg));
      chk({tag, ".obj_gnt"},  32'(obj_gnt),  32'(obj));
      chk({tag, ".busy"},     32'(busy),     32'(bz));
      chk({tag, ".bg_done"},  32'(bg_done),  32'(bd));
      chk({tag, ".obj_done"}, 32'(obj_done), 32'(od));
   endtask

   // Advance one edge, then check plot timing and pop the scoreboard on every plot.
   task automatic tick();
      pix_t e;
      @(posedge Clock);
      #1;
      chk("plot", 32'(plot), 32'(expPlot));
      if (plot === 1'b1) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("vga_x",      32'(vga_x),      32'(e.x));
            chk("vga_y",      32'(vga_y),      32'(e.y));
            chk("vga_colour", 32'(vga_colour), 32'(e.c));
         end
      end
      expPlot = 1'b0;
   endtask

   task automatic bgPix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input logic last, input bit willPlot);
      bg_valid = 1'b1; bg_x = x; bg_y = y; bg_colour = c; bg_last = last;
      if (willPlot) begin
         sb.push_back(pix_t'{x, y, c});
         expPlot = 1'b1;
      end
   endtask

   task automatic objPix(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input logic last, input bit willPlot);
      obj_valid = 1'b1; obj_x = x; obj_y = y; obj_colour = c; obj_last = last;
      if (willPlot) begin
         sb.push_back(pix_t'{x, y, c});
         expPlot = 1'b1;
      end
   endtask

   task automatic quiet();
      bg_req = 1'b0; bg_valid = 1'b0; bg_last = 1'b0;
      bg_x = '0; bg_y = '0; bg_colour = '0;
      obj_req = 1'b0; obj_valid = 1'b0; obj_last = 1'b0;
      obj_x = '0; obj_y = '0; obj_colour = '0;
   endtask

   initial begin
      bit clipOn;
`ifdef VGA_PLOT_CLIP_EN
      clipOn = 1'b1;
`else
      clipOn = 1'b0;
`endif
      quiet();
      Reset = 1'b1;
      #1;
      chkCtl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.plot",  32'(plot),  32'd0);
      chk("reset.vga_x", 32'(vga_x), 32'd0);
      chk("reset.vga_y", 32'(vga_y), 32'd0);
      chk("reset.vga_c", 32'(vga_colour), 32'd0);
      #11 Reset = 1'b0;
      tick();
      chkCtl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Background-only four-pixel burst ending on last.
      bg_req = 1'b1;
      tick();
      chkCtl("bg_grant", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bgPix(8'(10 + i), 7'd5, 3'b010, (i == 3), 1'b1);
         tick();
         chk("burst1.bg_done", 32'(bg_done), 32'(i == 3));
         chk("burst1.bg_gnt",  32'(bg_gnt),  32'(i != 3));
      end
      quiet();
      chkCtl("turn1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chkCtl("after_turn1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a background burst.
      bg_req = 1'b1;
      tick();
      chk("rst_burst.bg_gnt", 32'(bg_gnt), 32'd1);
      bgPix(8'd20, 7'd20, 3'd4, 1'b0, 1'b1);
      tick();
      bgPix(8'd21, 7'd20, 3'd4, 1'b0, 1'b0);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst.plot",   32'(plot),   32'd0);
      chk("async_rst.bg_gnt", 32'(bg_gnt), 32'd0);
      chk("async_rst.busy",   32'(busy),   32'd0);
      chk("async_rst.vga_x",  32'(vga_x),  32'd0);
      tick();
      chkCtl("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Release with both requesting: background wins the first tie, object the second.
      quiet();
      bg_req = 1'b1; obj_req = 1'b1;
      #2 Reset = 1'b0;
      tick();
      chkCtl("tie1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      bg_req = 1'b0;
      tick();
      chkCtl("abort_bg", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      bg_req = 1'b1;
      tick();
      chkCtl("idle_tie", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chkCtl("tie2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Object burst dropped after two pixels; background valid ignored meanwhile.
      bg_valid = 1'b1; bg_x = 8'd70; bg_y = 7'd70; bg_colour = 3'd1;
      objPix(8'd30, 7'd40, 3'd5, 1'b0, 1'b1);
      tick();
      objPix(8'd31, 7'd40, 3'd6, 1'b0, 1'b1);
      tick();
      chk("obj_mid.obj_gnt", 32'(obj_gnt), 32'd1);
      obj_req = 1'b0;
      objPix(8'd32, 7'd40, 3'd7, 1'b0, 1'b0);
      tick();
      chkCtl("abort_obj", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      bg_valid = 1'b0; obj_valid = 1'b0;
      tick();
      chkCtl("after_turn2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold.vga_x", 32'(vga_x), 32'd31);
      tick();
      chkCtl("regrant_bg", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Object pixel at (50,50) offered during the background grant, plus the clip boundary.
      obj_req = 1'b1;
      objPix(8'd50, 7'd50, 3'd3, 1'b0, 1'b0);
      tick();
      chk("ignore_obj.vga_x", 32'(vga_x), 32'd31);
      chk("ignore_obj.vga_y", 32'(vga_y), 32'd40);
      bgPix(8'd160, 7'd0, 3'd1, 1'b0, !clipOn);
      tick();
      chk("clip.vga_x", 32'(vga_x), clipOn ? 32'd31 : 32'd160);
      bgPix(8'd159, 7'd119, 3'd7, 1'b1, 1'b1);
      tick();
      chkCtl("clip_end", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      quiet();
      obj_req = 1'b1;
      tick();
      tick();
      chkCtl("obj_after_bg", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      obj_req = 1'b0;
      tick();
      tick();
      chkCtl("final_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("final.vga_x", 32'(vga_x), 32'd159);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
